fighter_fsm_param: RTL and testbench
====================================

Name: fighter_fsm_param

Overview:
Parametrised successor to the per-player fighter state machine. It advances one game frame per `frame_tick` rather than per clock. It latches asynchronous-to-tick hit/block pulses and sizes hit/blockstun from the attacker's move kind. New behaviours:
- hits interrupt any state;
- an input buffer lets attacks pressed late in recovery or stun come out on the first free frame.

It sits between the per-player input decoder and the sprite/collision logic; one instance per player.

Parameters:
CNT_W, 6, width of frame counter and frames_left.
ATK_START, 5, basic attack startup frames.
ATK_ACTIVE, 2, basic attack active frames.
ATK_RECOV, 16, basic attack recovery frames.
DIR_START, 4, directional attack startup frames.
DIR_ACTIVE, 3, directional attack active frames.
DIR_RECOV, 15, directional attack recovery frames.
HITSTUN_OFFSET, 1, hitstun = attacker recovery minus this.
BLOCKSTUN_OFFSET, 3, blockstun = attacker recovery minus this.
BUF_FRAMES, 3, input buffer window, in final frames of recovery/stun.
COUNTER_BONUS, 4, extra hitstun frames on counter hit (optional feature only).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
frame_tick  in  1  one-clk pulse; game state advances only on cycles with frame_tick=1
left  in  1  back input, level
right  in  1  forward input, level
attack  in  1  attack button, level
got_hit  in  1  one-clk pulse, any cycle
got_blocked  in  1  one-clk pulse, any cycle
hit_dir  in  1  sampled with got_hit/got_blocked: 1 = attacker used directional attack
state  out  4  encoded state
move_flag  out  1  Forward/Backward
attack_flag  out  1  basic start or active
directional_attack_flag  out  1  directional start or active
active_flag  out  1  either attack's active phase (hitbox live)
frames_left  out  CNT_W  frames remaining in current timed state, 0 otherwise

Behaviour:
- States and encoding: IDLE 0, BACK 1, FWD 2, ATK_S 3, ATK_A 4, ATK_R 5, DIR_S 6, DIR_A 7, DIR_R 8, HITSTUN 9, BLOCKSTUN 10.
- Unused encodings go to IDLE on the next tick.
- Reset values: state=IDLE, frames_left=0, all flags 0, pending event cleared, buffer cleared.
- Reset mid-attack or mid-stun aborts immediately.
- Event latch:
  - got_hit or got_blocked on any cycle sets pend_hit or pend_blk and captures hit_dir.
  - Both pulses on the same cycle: hit wins.
  - A later pulse before the tick overwrites (hit still dominates block).
  - Pending is consumed and cleared on the next tick.
- Tick priority: pending hit > pending block > timed-state progression > inputs.
- Pending hit/block in ANY state (including attacks and stun):
  - enter HITSTUN/BLOCKSTUN;
  - load frames_left = (hit_dir ? DIR_RECOV : ATK_RECOV) - offset;
  - clear the buffer.
  - A re-hit while already stunned reloads the count.
- IDLE/BACK/FWD with no event:
  - (left^right)&attack → DIR_S;
  - attack&~left&~right → ATK_S;
  - left only → BACK; right only → FWD;
  - otherwise IDLE.
  - left&right&attack → ATK_S.
- Timed states:
  - on entry, frames_left is loaded with the phase length;
  - each tick decrements it;
  - the tick on which frames_left==1 transitions to the next phase: S→A→R→exit.
  - Every phase and stun lasts exactly its parameter count in ticks.
- Input buffer:
  - In ATK_R, DIR_R, HITSTUN, BLOCKSTUN, a tick with frames_left<=BUF_FRAMES and attack=1 sets buf_valid and buf_dir=(left^right).
  - Later presses overwrite buf_dir.
- Exit from recovery/stun: if buf_valid, go to DIR_S or ATK_S per buf_dir, else IDLE. The buffer clears on exit.
- Flags and frames_left are registered alongside state; no combinational path from inputs.
- Counter arithmetic: stun and phase values must fit CNT_W. Elaboration error if any parameter ≥ 2^CNT_W, or if an offset ≥ its recovery.

Optional Feature:
FIGHTER_COUNTER_HIT_EN:
- Defined: a hit consumed while in ATK_S or DIR_S loads hitstun + COUNTER_BONUS (saturating at 2^CNT_W-1) and pulses the extra output `counter_hit` for one clk.
- Undefined: no `counter_hit` port; startup hits behave as ordinary hits.

Decomposition:
- Package fighter_pkg: state localparams/enum, default frame-count constants, a stun-length function (recov, offset, counter) shared with collision logic.
- Sub-module fighter_input_buffer: window compare, buf_valid/buf_dir latch, clear on exit/hit.
- The FSM and event latch stay in the top module.

Test Plan:
- Basic attack: attack=1 on tick 0 → ATK_S for ticks 1-5, ATK_A 6-7 (active_flag=1), ATK_R 8-23, IDLE on tick 24.
- Directional: right=1, attack=1 → DIR_S 4 ticks, DIR_A 3, DIR_R 15; directional_attack_flag=1 only during S/A.
- Stun sizing: got_hit with hit_dir=0 → HITSTUN 15 ticks; got_blocked with hit_dir=1 → BLOCKSTUN 12 ticks. got_hit and got_blocked on the same clk → HITSTUN.
- Off-tick event plus interrupt: got_hit pulse 3 clks before a tick while in ATK_A → HITSTUN on that tick, frames_left=15, buffer empty.
- Buffer: attack pressed at ATK_R frames_left=3 → after recovery goes straight to ATK_S (no IDLE tick). Pressed at frames_left=4 → IDLE.
- Reset asserted mid-HITSTUN → next clk state=0, frames_left=0, flags 0. With FIGHTER_COUNTER_HIT_EN, hit in ATK_S → hitstun 19, counter_hit pulse.

Source files
------------

// File: rtl/fighter_pkg.sv
// Shared fighter definitions: state encoding, default frame data and the stun-length
// helper that the collision logic uses to size hitstun/blockstun.
package fighter_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_BACK      = 4'd1,
        S_FWD       = 4'd2,
        S_ATK_S     = 4'd3,
        S_ATK_A     = 4'd4,
        S_ATK_R     = 4'd5,
        S_DIR_S     = 4'd6,
        S_DIR_A     = 4'd7,
        S_DIR_R     = 4'd8,
        S_HITSTUN   = 4'd9,
        S_BLOCKSTUN = 4'd10
    } state_t;

    localparam int DEF_CNT_W            = 6;
    localparam int DEF_ATK_START        = 5;
    localparam int DEF_ATK_ACTIVE       = 2;
    localparam int DEF_ATK_RECOV        = 16;
    localparam int DEF_DIR_START        = 4;
    localparam int DEF_DIR_ACTIVE       = 3;
    localparam int DEF_DIR_RECOV        = 15;
    localparam int DEF_HITSTUN_OFFSET   = 1;
    localparam int DEF_BLOCKSTUN_OFFSET = 3;
    localparam int DEF_BUF_FRAMES       = 3;
    localparam int DEF_COUNTER_BONUS    = 4;

    // Stun = attacker recovery minus offset; a counter hit adds a bonus, clamped to max_val.
    function automatic int stun_len(input int recov, input int offset, input int bonus,
                                    input logic counter, input int max_val);
        int len;
        len = recov - offset;
        if (counter) begin
            len = len + bonus;
            if (len > max_val) len = max_val;
        end
        return len;
    endfunction

endpackage

// File: rtl/fighter_input_buffer.sv
// Attack input buffer: remembers a press made in the last frames of recovery/stun so the
// attack can start on the first free frame.
module fighter_input_buffer #(
    parameter int CNT_W      = 6,
    parameter int BUF_FRAMES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             in_window_state,
    input  logic [CNT_W-1:0] frames_left,
    input  logic             attack,
    input  logic             dir,
    input  logic             clear,
    output logic             take_valid,
    output logic             take_dir
);

    localparam logic [CNT_W-1:0] BUF_LIM = CNT_W'(BUF_FRAMES);

    logic buf_valid;
    logic buf_dir;
    logic press;

    assign press = tick & in_window_state & attack & (frames_left <= BUF_LIM);

    // A press on the exit tick itself still counts, so the FSM sees it merged here.
    assign take_valid = buf_valid | press;
    assign take_dir   = press ? dir : buf_dir;

    always_ff @(posedge clk) begin
        if (reset || (tick && clear)) begin
            buf_valid <= 1'b0;
            buf_dir   <= 1'b0;
        end else if (press) begin
            buf_valid <= 1'b1;
            buf_dir   <= dir;
        end
    end

endmodule

// File: rtl/fighter_fsm_param.sv
// Per-player fighter FSM advancing one frame per frame_tick, with hit/block event latch.
// Optional macro FIGHTER_COUNTER_HIT_EN: counter-hit bonus stun and counter_hit pulse.
module fighter_fsm_param
    import fighter_pkg::*;
#(
    parameter int CNT_W            = DEF_CNT_W,
    parameter int ATK_START        = DEF_ATK_START,
    parameter int ATK_ACTIVE       = DEF_ATK_ACTIVE,
    parameter int ATK_RECOV        = DEF_ATK_RECOV,
    parameter int DIR_START        = DEF_DIR_START,
    parameter int DIR_ACTIVE       = DEF_DIR_ACTIVE,
    parameter int DIR_RECOV        = DEF_DIR_RECOV,
    parameter int HITSTUN_OFFSET   = DEF_HITSTUN_OFFSET,
    parameter int BLOCKSTUN_OFFSET = DEF_BLOCKSTUN_OFFSET,
    parameter int BUF_FRAMES       = DEF_BUF_FRAMES,
    parameter int COUNTER_BONUS    = DEF_COUNTER_BONUS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             left,
    input  logic             right,
    input  logic             attack,
    input  logic             got_hit,
    input  logic             got_blocked,
    input  logic             hit_dir,
    output logic [3:0]       state,
    output logic             move_flag,
    output logic             attack_flag,
    output logic             directional_attack_flag,
    output logic             active_flag,
`ifdef FIGHTER_COUNTER_HIT_EN
    output logic             counter_hit,
`endif
    output logic [CNT_W-1:0] frames_left
);

    localparam int MAXV = (1 << CNT_W) - 1;

    if (ATK_START > MAXV || ATK_ACTIVE > MAXV || ATK_RECOV > MAXV ||
        DIR_START > MAXV || DIR_ACTIVE > MAXV || DIR_RECOV > MAXV ||
        HITSTUN_OFFSET > MAXV || BLOCKSTUN_OFFSET > MAXV ||
        BUF_FRAMES > MAXV || COUNTER_BONUS > MAXV) begin : g_bad_width
        $error("fighter_fsm_param: a frame parameter does not fit CNT_W");
    end
    if (HITSTUN_OFFSET >= ATK_RECOV || HITSTUN_OFFSET >= DIR_RECOV ||
        BLOCKSTUN_OFFSET >= ATK_RECOV || BLOCKSTUN_OFFSET >= DIR_RECOV) begin : g_bad_offset
        $error("fighter_fsm_param: stun offset must be smaller than recovery");
    end

    localparam logic [CNT_W-1:0] L_ATK_START  = CNT_W'(ATK_START);
    localparam logic [CNT_W-1:0] L_ATK_ACTIVE = CNT_W'(ATK_ACTIVE);
    localparam logic [CNT_W-1:0] L_ATK_RECOV  = CNT_W'(ATK_RECOV);
    localparam logic [CNT_W-1:0] L_DIR_START  = CNT_W'(DIR_START);
    localparam logic [CNT_W-1:0] L_DIR_ACTIVE = CNT_W'(DIR_ACTIVE);
    localparam logic [CNT_W-1:0] L_DIR_RECOV  = CNT_W'(DIR_RECOV);
    localparam logic [CNT_W-1:0] L_ONE        = CNT_W'(1);

    logic [3:0]       state_r, state_nxt;
    logic [CNT_W-1:0] frames_nxt;
    logic             pend_hit, pend_blk, pend_dir;
    logic             eff_hit, eff_blk, eff_dir;
    logic             is_counter, counter_nxt;
    logic             buf_clear, take_valid, take_dir, in_window;
    logic             expire;
    int               recov;

    // Events arriving on the tick cycle itself are merged with the latched ones.
    assign eff_hit = pend_hit | got_hit;
    assign eff_blk = pend_blk | got_blocked;
    assign eff_dir = got_hit ? hit_dir :
                     pend_hit ? pend_dir :
                     got_blocked ? hit_dir : pend_dir;

    always_ff @(posedge clk) begin
        if (reset || frame_tick) begin
            pend_hit <= 1'b0;
            pend_blk <= 1'b0;
            pend_dir <= 1'b0;
        end else if (got_hit) begin
            pend_hit <= 1'b1;
            pend_blk <= 1'b0;
            pend_dir <= hit_dir;
        end else if (got_blocked && !pend_hit) begin
            pend_blk <= 1'b1;
            pend_dir <= hit_dir;
        end
    end

`ifdef FIGHTER_COUNTER_HIT_EN
    assign is_counter = (state_r == S_ATK_S) || (state_r == S_DIR_S);
`else
    assign is_counter = 1'b0;
`endif

    assign in_window = (state_r == S_ATK_R) || (state_r == S_DIR_R) ||
                       (state_r == S_HITSTUN) || (state_r == S_BLOCKSTUN);
    assign expire    = (frames_left <= L_ONE);

    fighter_input_buffer #(
        .CNT_W      (CNT_W),
        .BUF_FRAMES (BUF_FRAMES)
    ) u_buf (
        .clk             (clk),
        .reset           (reset),
        .tick            (frame_tick),
        .in_window_state (in_window),
        .frames_left     (frames_left),
        .attack          (attack),
        .dir             (left ^ right),
        .clear           (buf_clear),
        .take_valid      (take_valid),
        .take_dir        (take_dir)
    );

    always_comb begin
        state_nxt   = state_r;
        frames_nxt  = frames_left;
        buf_clear   = 1'b0;
        counter_nxt = 1'b0;
        recov       = eff_dir ? DIR_RECOV : ATK_RECOV;
        if (frame_tick) begin
            if (eff_hit) begin
                state_nxt   = S_HITSTUN;
                frames_nxt  = CNT_W'(stun_len(recov, HITSTUN_OFFSET, COUNTER_BONUS,
                                              is_counter, MAXV));
                buf_clear   = 1'b1;
                counter_nxt = is_counter;
            end else if (eff_blk) begin
                state_nxt  = S_BLOCKSTUN;
                frames_nxt = CNT_W'(stun_len(recov, BLOCKSTUN_OFFSET, COUNTER_BONUS,
                                             1'b0, MAXV));
                buf_clear  = 1'b1;
            end else begin
                case (state_r)
                    S_IDLE, S_BACK, S_FWD: begin
                        frames_nxt = '0;
                        if (attack && (left ^ right)) begin
                            state_nxt  = S_DIR_S;
                            frames_nxt = L_DIR_START;
                        end else if (attack) begin
                            state_nxt  = S_ATK_S;
                            frames_nxt = L_ATK_START;
                        end else if (left && !right) begin
                            state_nxt = S_BACK;
                        end else if (right && !left) begin
                            state_nxt = S_FWD;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end
                    S_ATK_S: begin
                        state_nxt  = expire ? S_ATK_A : S_ATK_S;
                        frames_nxt = expire ? L_ATK_ACTIVE : frames_left - L_ONE;
                    end
                    S_ATK_A: begin
                        state_nxt  = expire ? S_ATK_R : S_ATK_A;
                        frames_nxt = expire ? L_ATK_RECOV : frames_left - L_ONE;
                    end
                    S_DIR_S: begin
                        state_nxt  = expire ? S_DIR_A : S_DIR_S;
                        frames_nxt = expire ? L_DIR_ACTIVE : frames_left - L_ONE;
                    end
                    S_DIR_A: begin
                        state_nxt  = expire ? S_DIR_R : S_DIR_A;
                        frames_nxt = expire ? L_DIR_RECOV : frames_left - L_ONE;
                    end
                    S_ATK_R, S_DIR_R, S_HITSTUN, S_BLOCKSTUN: begin
                        if (expire) begin
                            buf_clear = 1'b1;
                            if (take_valid && take_dir) begin
                                state_nxt  = S_DIR_S;
                                frames_nxt = L_DIR_START;
                            end else if (take_valid) begin
                                state_nxt  = S_ATK_S;
                                frames_nxt = L_ATK_START;
                            end else begin
                                state_nxt  = S_IDLE;
                                frames_nxt = '0;
                            end
                        end else begin
                            frames_nxt = frames_left - L_ONE;
                        end
                    end
                    default: begin
                        state_nxt  = S_IDLE;
                        frames_nxt = '0;
                    end
                endcase
            end
        end
    end

    // Flags are derived from the next state so they register together with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r                 <= S_IDLE;
            frames_left             <= '0;
            move_flag               <= 1'b0;
            attack_flag             <= 1'b0;
            directional_attack_flag <= 1'b0;
            active_flag             <= 1'b0;
        end else begin
            state_r                 <= state_nxt;
            frames_left             <= frames_nxt;
            move_flag               <= (state_nxt == S_BACK) || (state_nxt == S_FWD);
            attack_flag             <= (state_nxt == S_ATK_S) || (state_nxt == S_ATK_A);
            directional_attack_flag <= (state_nxt == S_DIR_S) || (state_nxt == S_DIR_A);
            active_flag             <= (state_nxt == S_ATK_A) || (state_nxt == S_DIR_A);
        end
    end

`ifdef FIGHTER_COUNTER_HIT_EN
    always_ff @(posedge clk) begin
        if (reset) counter_hit <= 1'b0;
        else       counter_hit <= counter_nxt;
    end
`else
    logic unused_counter;
    assign unused_counter = counter_nxt;
`endif

    assign state = state_r;

endmodule

// File: tb/tb_fighter_fsm_param.sv
// Directed bench for fighter_fsm_param: vector table plus multi-tick attack/stun/buffer sequences.
module tb_fighter_fsm_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       left = 1'b0, right = 1'b0, attack = 1'b0;
    logic       got_hit = 1'b0, got_blocked = 1'b0, hit_dir = 1'b0;
    logic [3:0] state;
    logic       move_flag, attack_flag, directional_attack_flag, active_flag;
    logic [5:0] frames_left;
`ifdef FIGHTER_COUNTER_HIT_EN
    logic       counter_hit;
`endif

    int applied = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fighter_fsm_param dut (
        .clk                     (clk),
        .reset                   (reset),
        .frame_tick              (frame_tick),
        .left                    (left),
        .right                   (right),
        .attack                  (attack),
        .got_hit                 (got_hit),
        .got_blocked             (got_blocked),
        .hit_dir                 (hit_dir),
        .state                   (state),
        .move_flag               (move_flag),
        .attack_flag             (attack_flag),
        .directional_attack_flag (directional_attack_flag),
        .active_flag             (active_flag),
`ifdef FIGHTER_COUNTER_HIT_EN
        .counter_hit             (counter_hit),
`endif
        .frames_left             (frames_left)
    );

    typedef struct {
        logic       rst, l, r, a, hit, blk, dir, tick;
        logic [3:0] st;
        logic [5:0] fl;
        logic [3:0] flg;   // {move, attack, directional, active}
    } vec_t;

    vec_t vecs[23];

    task automatic check(input string name, input int got, input int exp);
        applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_out(input string name, input int st, input int fl, input int flg);
        check({name, ".state"}, int'(state), st);
        check({name, ".frames"}, int'(frames_left), fl);
        check({name, ".flags"},
              int'({move_flag, attack_flag, directional_attack_flag, active_flag}), flg);
    endtask

    // One frame: inputs held for the tick clock, then one quiet clock before sampling.
    task automatic do_tick(input logic a, input logic l, input logic r);
        @(negedge clk);
        attack = a; left = l; right = r; frame_tick = 1'b1;
        @(negedge clk);
        attack = 1'b0; left = 1'b0; right = 1'b0; frame_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_event(input logic h, input logic b, input logic d);
        @(negedge clk);
        got_hit = h; got_blocked = b; hit_dir = d;
        @(negedge clk);
        got_hit = 1'b0; got_blocked = 1'b0; hit_dir = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        //            rst   l     r     a     hit   blk   dir   tick  st  fl  flg
        vecs[0]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 4'd1, 6'd0, 4'b1000};
        vecs[1]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 4'd1, 6'd0, 4'b1000};
        vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 4'd2, 6'd0, 4'b1000};
        vecs[3]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 4'd0, 6'd0, 4'b0000};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 4'd0, 6'd0, 4'b0000};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 4'd9, 6'd15,4'b0000};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 4'd9, 6'd15,4'b0000};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 4'd10,6'd12,4'b0000};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 4'd10,6'd11,4'b0000};
        vecs[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 4'd10,6'd11,4'b0000};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 4'd9, 6'd15,4'b0000};
        vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 4'd9, 6'd15,4'b0000};
        vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 4'd9, 6'd15,4'b0000};
        vecs[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 4'd9, 6'd14,4'b0000};
        vecs[14] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 4'd9, 6'd14,4'b0000};
        vecs[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 4'd9, 6'd14,4'b0000};
        vecs[16] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 4'd9, 6'd14,4'b0000};
        vecs[17] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 4'd9, 6'd13,4'b0000};
        vecs[18] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'd0, 6'd0, 4'b0000};
        vecs[19] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 4'd3, 6'd5, 4'b0100};
        vecs[20] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 4'd0, 6'd0, 4'b0000};
        vecs[21] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 4'd6, 6'd4, 4'b0010};
        vecs[22] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 4'd6, 6'd3, 4'b0010};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_out("reset", 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; left = vecs[i].l; right = vecs[i].r; attack = vecs[i].a;
            got_hit = vecs[i].hit; got_blocked = vecs[i].blk; hit_dir = vecs[i].dir;
            frame_tick = vecs[i].tick;
            @(negedge clk);
            reset = 1'b0; left = 1'b0; right = 1'b0; attack = 1'b0;
            got_hit = 1'b0; got_blocked = 1'b0; hit_dir = 1'b0; frame_tick = 1'b0;
            check_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].fl, vecs[i].flg);
        end

        // Basic attack: 5 startup, 2 active, 16 recovery, then IDLE.
        do_reset();
        do_tick(1'b1, 1'b0, 1'b0);
        check_out("atk.k0", 3, 5, 4'b0100);
        for (int k = 1; k <= 23; k++) begin
            int es, ef, eg;
            do_tick(1'b0, 1'b0, 1'b0);
            if (k <= 4)       begin es = 3; ef = 5 - k;  eg = 4'b0100; end
            else if (k <= 6)  begin es = 4; ef = 7 - k;  eg = 4'b0101; end
            else if (k <= 22) begin es = 5; ef = 23 - k; eg = 4'b0000; end
            else              begin es = 0; ef = 0;      eg = 4'b0000; end
            check_out($sformatf("atk.k%0d", k), es, ef, eg);
        end

        // Directional: 4 startup, 3 active, 15 recovery.
        do_reset();
        do_tick(1'b1, 1'b0, 1'b1);
        check_out("dir.k0", 6, 4, 4'b0010);
        for (int k = 1; k <= 22; k++) begin
            int es, ef, eg;
            do_tick(1'b0, 1'b0, 1'b0);
            if (k <= 3)       begin es = 6; ef = 4 - k;  eg = 4'b0010; end
            else if (k <= 6)  begin es = 7; ef = 7 - k;  eg = 4'b0011; end
            else if (k <= 21) begin es = 8; ef = 22 - k; eg = 4'b0000; end
            else              begin es = 0; ef = 0;      eg = 4'b0000; end
            check_out($sformatf("dir.k%0d", k), es, ef, eg);
        end

        // Hit latched 3 clocks before the tick interrupts the active phase.
        do_reset();
        do_tick(1'b1, 1'b0, 1'b0);
        ticks(5);
        check_out("int.pre", 4, 2, 4'b0101);
        pulse_event(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        do_tick(1'b0, 1'b0, 1'b0);
        check_out("int.hitstun", 9, 15, 4'b0000);
        ticks(14);
        check_out("int.last", 9, 1, 4'b0000);
        do_tick(1'b0, 1'b0, 1'b0);
        check_out("int.exit", 0, 0, 4'b0000);

        // A buffered press is discarded when a hit lands.
        do_reset();
        do_tick(1'b1, 1'b0, 1'b0);
        ticks(20);
        check_out("bclr.fl3", 5, 3, 4'b0000);
        do_tick(1'b1, 1'b0, 1'b0);
        pulse_event(1'b1, 1'b0, 1'b0);
        do_tick(1'b0, 1'b0, 1'b0);
        check_out("bclr.stun", 9, 15, 4'b0000);
        ticks(15);
        check_out("bclr.exit", 0, 0, 4'b0000);

        // Press at frames_left=3 chains straight into the next attack.
        do_reset();
        do_tick(1'b1, 1'b0, 1'b0);
        ticks(20);
        do_tick(1'b1, 1'b0, 1'b0);
        check_out("buf3.press", 5, 2, 4'b0000);
        ticks(1);
        check_out("buf3.fl1", 5, 1, 4'b0000);
        ticks(1);
        check_out("buf3.chain", 3, 5, 4'b0100);

        // Press at frames_left=4 is outside the window.
        do_reset();
        do_tick(1'b1, 1'b0, 1'b0);
        ticks(19);
        check_out("buf4.fl4", 5, 4, 4'b0000);
        do_tick(1'b1, 1'b0, 1'b0);
        ticks(3);
        check_out("buf4.exit", 0, 0, 4'b0000);

        // Directional press buffered in blockstun.
        do_reset();
        pulse_event(1'b0, 1'b1, 1'b1);
        do_tick(1'b0, 1'b0, 1'b0);
        check_out("bstun.entry", 10, 12, 4'b0000);
        ticks(9);
        do_tick(1'b1, 1'b0, 1'b1);
        check_out("bstun.press", 10, 2, 4'b0000);
        ticks(2);
        check_out("bstun.chain", 6, 4, 4'b0010);

        // Reset in the middle of hitstun.
        do_reset();
        pulse_event(1'b1, 1'b0, 1'b0);
        do_tick(1'b0, 1'b0, 1'b0);
        ticks(3);
        check_out("rst.stun", 9, 12, 4'b0000);
        do_reset();
        check_out("rst.after", 0, 0, 4'b0000);
        ticks(1);
        check_out("rst.idle", 0, 0, 4'b0000);

`ifdef FIGHTER_COUNTER_HIT_EN
        // Counter hit during startup: 15 + 4 frames and a one-clock pulse.
        do_reset();
        do_tick(1'b1, 1'b0, 1'b0);
        pulse_event(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("ch.pulse", int'(counter_hit), 1);
        check_out("ch.stun", 9, 19, 4'b0000);
        @(negedge clk);
        check("ch.pulse_end", int'(counter_hit), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
